// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle: pipeline-side hazard inputs and the stall/flush/multi-cycle controls.
// master = hazard controller, slave = pipeline (or bench) side.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1D;
    logic [4:0]       rs2D;
    logic [4:0]       rdE;
    logic             LoadE;
    logic             PCSrcE;
    logic             McReqE;
    logic             McDone;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic             McStart;
    logic             McTimeout;
    logic [CNT_W-1:0] StallCount;

    modport master (
        input  rs1D, rs2D, rdE, LoadE, PCSrcE, McReqE, McDone,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
               McStart, McTimeout, StallCount
    );

    modport slave (
        output rs1D, rs2D, rdE, LoadE, PCSrcE, McReqE, McDone,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
               McStart, McTimeout, StallCount
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: load-use stall, taken-branch flush, multi-cycle unit sequencing, stall counter.
// Define HAZARD_MC_EN to enable the multi-cycle (MUL/DIV) start/done sequencing with watchdog.
module hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.master hz
);

    logic             lwStall;
    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             flushD;
    logic             flushE;
    logic             flushM;
    logic             mcStart;
    logic             mcTimeout;
    logic [CNT_W-1:0] stallCount;

    assign lwStall = hz.LoadE & (hz.rdE != 5'd0) &
                     ((hz.rs1D == hz.rdE) | (hz.rs2D == hz.rdE));

`ifdef HAZARD_MC_EN

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TMO = 8'(MC_TIMEOUT);

    state_t     state;
    state_t     nextState;
    logic [7:0] wcnt;
    logic [7:0] nextWcnt;
    logic       setTimeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            wcnt      <= 8'd0;
            mcTimeout <= 1'b0;
        end else begin
            state <= nextState;
            wcnt  <= nextWcnt;
            if (setTimeout) begin
                mcTimeout <= 1'b1;
            end
        end
    end

    // McDone wins over the watchdog when both land on the final wait cycle.
    always_comb begin
        nextState  = state;
        nextWcnt   = wcnt;
        setTimeout = 1'b0;
        case (state)
            RUN: begin
                if (hz.McReqE) begin
                    nextState = MC_WAIT;
                    nextWcnt  = 8'd1;
                end
            end
            MC_WAIT: begin
                if (hz.McDone) begin
                    nextState = RUN;
                end else if (wcnt >= TMO) begin
                    nextState  = RUN;
                    setTimeout = 1'b1;
                end else begin
                    nextWcnt = wcnt + 8'd1;
                end
            end
            default: begin
                nextState = RUN;
            end
        endcase
    end

    always_comb begin
        stallF  = lwStall & ~hz.PCSrcE;
        stallD  = lwStall & ~hz.PCSrcE;
        stallE  = 1'b0;
        flushD  = hz.PCSrcE;
        flushE  = lwStall | hz.PCSrcE;
        flushM  = 1'b0;
        mcStart = 1'b0;
        if (reset) begin
            stallF = 1'b0;
            stallD = 1'b0;
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (hz.McReqE) begin
                        stallF  = 1'b1;
                        stallD  = 1'b1;
                        stallE  = 1'b1;
                        flushD  = 1'b0;
                        flushE  = 1'b0;
                        flushM  = 1'b1;
                        mcStart = 1'b1;
                    end
                end
                MC_WAIT: begin
                    // Release cycle (done or watchdog) lets the op in E advance to M.
                    flushD = 1'b0;
                    flushE = 1'b0;
                    if (!hz.McDone && (wcnt < TMO)) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        stallE = 1'b1;
                        flushM = 1'b1;
                    end else begin
                        stallF = 1'b0;
                        stallD = 1'b0;
                    end
                end
                default: begin
                    stallF = 1'b0;
                    stallD = 1'b0;
                end
            endcase
        end
    end

`else

    logic unusedMcInputs;
    assign unusedMcInputs = ^{hz.McReqE, hz.McDone, MC_TIMEOUT[0]};

    always_comb begin
        stallF  = lwStall & ~hz.PCSrcE;
        stallD  = lwStall & ~hz.PCSrcE;
        stallE  = 1'b0;
        flushD  = hz.PCSrcE;
        flushE  = lwStall | hz.PCSrcE;
        flushM  = 1'b0;
        mcStart = 1'b0;
        if (reset) begin
            stallF = 1'b0;
            stallD = 1'b0;
            flushD = 1'b1;
            flushE = 1'b1;
        end
    end

    assign mcTimeout = 1'b0;

`endif

    // Performance counter of fetch-stall cycles, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
        end else if (stallF && (stallCount != '1)) begin
            stallCount <= stallCount + CNT_W'(1);
        end
    end

    assign hz.StallF     = stallF;
    assign hz.StallD     = stallD;
    assign hz.StallE     = stallE;
    assign hz.FlushD     = flushD;
    assign hz.FlushE     = flushE;
    assign hz.FlushM     = flushM;
    assign hz.McStart    = mcStart;
    assign hz.McTimeout  = mcTimeout;
    assign hz.StallCount = stallCount;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; expectations follow HAZARD_MC_EN when defined.
module tb_hazard_ctrl;

    localparam int MC_TIMEOUT = 6;
    localparam int CNT_W      = 4;

`ifdef HAZARD_MC_EN
    localparam bit MC = 1'b1;
`else
    localparam bit MC = 1'b0;
`endif

    // Vector order: {StallF, StallD, StallE, FlushD, FlushE, FlushM, McStart}
    localparam logic [6:0] V_IDLE  = 7'b0000000;
    localparam logic [6:0] V_RST   = MC ? 7'b0001110 : 7'b0001100;
    localparam logic [6:0] V_LU    = 7'b1100100;
    localparam logic [6:0] V_BR    = 7'b0001100;
    localparam logic [6:0] V_START = MC ? 7'b1110011 : 7'b0000000;
    localparam logic [6:0] V_WAIT  = MC ? 7'b1110010 : 7'b0000000;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(
        .MC_TIMEOUT (MC_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            assert (!(hz.McReqE && hz.PCSrcE))
                else $error("[TB] illegal stimulus: McReqE together with PCSrcE");
        end
    end

    task automatic applyStimulus(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic load, input logic pcsrc,
                                 input logic mcreq, input logic mcdone);
        @(posedge clk);
        #1;
        reset     = rst;
        hz.rs1D   = rs1;
        hz.rs2D   = rs2;
        hz.rdE    = rd;
        hz.LoadE  = load;
        hz.PCSrcE = pcsrc;
        hz.McReqE = mcreq;
        hz.McDone = mcdone;
        #3;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
            else begin
                errors++;
                $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
            end
    endtask

    function automatic logic [31:0] ctlVec();
        return {25'd0, hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM, hz.McStart};
    endfunction

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        hz.rs1D   = 5'd0;
        hz.rs2D   = 5'd0;
        hz.rdE    = 5'd0;
        hz.LoadE  = 1'b0;
        hz.PCSrcE = 1'b0;
        hz.McReqE = 1'b0;
        hz.McDone = 1'b0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_ctl", ctlVec(), 32'(V_RST));
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_count", 32'(hz.StallCount), 32'd0);
        checkOutput("reset_timeout", 32'(hz.McTimeout), 32'd0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("idle_ctl", ctlVec(), 32'(V_IDLE));

        // Load-use on rs2, then the same with rdE = x0
        applyStimulus(0, 1, 5, 5, 1, 0, 0, 0);
        checkOutput("loaduse_ctl", ctlVec(), 32'(V_LU));
        applyStimulus(0, 1, 5, 0, 1, 0, 0, 0);
        checkOutput("loaduse_count", 32'(hz.StallCount), 32'd1);
        checkOutput("loaduse_x0_ctl", ctlVec(), 32'(V_IDLE));

        // Taken branch masks a coincident load-use match
        applyStimulus(0, 3, 0, 3, 1, 1, 0, 0);
        checkOutput("branch_ctl", ctlVec(), 32'(V_BR));
        checkOutput("branch_count", 32'(hz.StallCount), 32'd1);

        // Multi-cycle op, McDone five cycles after McStart
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("mc_start_ctl", ctlVec(), 32'(V_START));
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("mc_wait%0d_ctl", i), ctlVec(), 32'(V_WAIT));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("mc_done_ctl", ctlVec(), 32'(V_IDLE));
        checkOutput("mc_done_count", 32'(hz.StallCount), MC ? 32'd6 : 32'd1);
        applyStimulus(0, 1, 5, 5, 1, 0, 0, 0);
        checkOutput("mc_back_run_ctl", ctlVec(), 32'(V_LU));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mc_back_run_count", 32'(hz.StallCount), MC ? 32'd7 : 32'd2);

        // Watchdog: McDone never arrives
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("tmo_start_ctl", ctlVec(), 32'(V_START));
        for (int i = 1; i < MC_TIMEOUT; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("tmo_wait%0d_ctl", i), ctlVec(), 32'(V_WAIT));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("tmo_release_ctl", ctlVec(), 32'(V_IDLE));
        checkOutput("tmo_before_flag", 32'(hz.McTimeout), 32'd0);
        checkOutput("tmo_count", 32'(hz.StallCount), MC ? 32'd13 : 32'd2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("tmo_late_done_ctl", ctlVec(), 32'(V_IDLE));
        checkOutput("tmo_flag", 32'(hz.McTimeout), MC ? 32'd1 : 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("tmo_flag_sticky", 32'(hz.McTimeout), MC ? 32'd1 : 32'd0);
        checkOutput("tmo_count_hold", 32'(hz.StallCount), MC ? 32'd13 : 32'd2);

        // Reset asserted in the second MC_WAIT cycle
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("rst_mid_start_ctl", ctlVec(), 32'(V_START));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_mid_wait1_ctl", ctlVec(), 32'(V_WAIT));
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_mid_ctl", ctlVec(), 32'(V_RST));
        checkOutput("rst_mid_count_sat", 32'(hz.StallCount), MC ? 32'd15 : 32'd2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("rst_mid_done_ctl", ctlVec(), 32'(V_IDLE));
        checkOutput("rst_mid_count", 32'(hz.StallCount), 32'd0);
        checkOutput("rst_mid_timeout", 32'(hz.McTimeout), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_mid_after_ctl", ctlVec(), 32'(V_IDLE));

        // Saturation: 20 consecutive load-use stalls on a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 7, 2, 7, 1, 0, 0, 0);
            checkOutput($sformatf("sat%0d_count", i), 32'(hz.StallCount), (i > 15) ? 32'd15 : 32'(i));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("sat_final_count", 32'(hz.StallCount), 32'd15);
        checkOutput("sat_final_ctl", ctlVec(), 32'(V_IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
